// File: rtl/hilo_md_unit.sv
// HI/LO multiply/divide unit: 33-cycle shift-add multiply and restoring divide,
// plus single-cycle MTHI/MTLO writes.
module hilo_md_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  alu_ctrl,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic        divideZero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [4:0] MULT_OP  = 5'b00110;
  localparam logic [4:0] MULTU_OP = 5'b00111;
  localparam logic [4:0] DIV_OP   = 5'b01000;
  localparam logic [4:0] DIVU_OP  = 5'b01001;
  localparam logic [4:0] MTHI_OP  = 5'b10010;
  localparam logic [4:0] MTLO_OP  = 5'b10011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] opb_q, opb_d;
  logic        is_div_q, is_div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;

  logic        op_is_mul, op_is_div, op_signed;
  logic        sign_a, sign_b;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic        sub_ok;
  logic [31:0] rem_sub;
  logic [63:0] prod;

  function automatic logic [31:0] magnitude(input logic [31:0] v, input logic is_signed);
    magnitude = (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
    cond_neg32 = neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
    cond_neg64 = neg ? (~v + 64'd1) : v;
  endfunction

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_d     = acc_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    op_is_mul = (alu_ctrl == MULT_OP) || (alu_ctrl == MULTU_OP);
    op_is_div = (alu_ctrl == DIV_OP) || (alu_ctrl == DIVU_OP);
    op_signed = (alu_ctrl == MULT_OP) || (alu_ctrl == DIV_OP);
    sign_a    = op_signed & op1[31];
    sign_b    = op_signed & op2[31];

    // Multiply step: acc holds {partial product high, remaining multiplier bits}
    mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    // Divide step: acc holds {partial remainder, dividend/quotient shift register}
    rem_sh  = {acc_q[63:32], acc_q[31]};
    sub_ok  = (rem_sh >= {1'b0, opb_q});
    rem_sub = rem_sh[31:0] - opb_q;
    prod    = cond_neg64(acc_q, neg_res_q);

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          if (op_is_mul || (op_is_div && (op2 != 32'd0))) begin
            acc_d     = {32'd0, magnitude(op1, op_signed)};
            opb_d     = magnitude(op2, op_signed);
            is_div_d  = op_is_div;
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            count_d   = 5'd0;
            state_d   = RUN;
          end else if (op_is_div) begin
            dz_d = 1'b1;
          end else if (alu_ctrl == MTHI_OP) begin
            hi_d = op1;
          end else if (alu_ctrl == MTLO_OP) begin
            lo_d = op1;
          end
        end
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          count_d = 5'd0;
        end else begin
          if (is_div_q) begin
            acc_d = {(sub_ok ? rem_sub : rem_sh[31:0]), acc_q[30:0], sub_ok};
          end else begin
            acc_d = {mul_sum, acc_q[31:1]};
          end
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d = FIX;
            count_d = 5'd0;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          if (is_div_q) begin
            hi_d = cond_neg32(acc_q[63:32], neg_rem_q);
            lo_d = cond_neg32(acc_q[31:0], neg_res_q);
          end else begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = 5'd0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      acc_q     <= 64'd0;
      opb_q     <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_q     <= acc_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign divideZero = dz_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule
